dmx_framer: RTL

Parametrised DMX512 frame generator, successor to the fixed 12 MHz / 512-slot packetizer. It produces the serial DMX line (idle, break, mark-after-break, start code, N data slots) at a configurable clock/baud with configurable break/MAB/idle lengths. It adds a runtime slot count, a runtime start code, enable gating and frame strobes. It fetches slot data through an address/data pull interface and feeds dmx_modulator's data input.

---
 rtl/dmx_framer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/dmx_framer.sv
// DMX512 frame generator: idle mark, break, mark-after-break, start code and N data
// slots (8N2, LSB first), with slot data pulled one slot ahead through slot_count/slot_byte.
module dmx_framer #(
  parameter int CLK_HZ     = 12_000_000,
  parameter int BAUD       = 250_000,
  parameter int BREAK_BITS = 25,
  parameter int MAB_BITS   = 3,
  parameter int IDLE_BITS  = 2,
  parameter int MAX_SLOTS  = 512,
  parameter int SW         = $clog2(MAX_SLOTS + 1)
) (
  input  logic          CLK12,
  input  logic          RST,
  input  logic          enable,
  input  logic [SW-1:0] num_slots,
  input  logic [7:0]    start_code,
  output logic [SW-1:0] slot_count,
  input  logic [7:0]    slot_byte,
  output logic          dmx_data,
  output logic          frame_start,
  output logic          frame_done,
  output logic          busy
);

  localparam int DIV  = CLK_HZ / BAUD;
  localparam int DW   = $clog2(DIV);
  localparam int M1   = (BREAK_BITS > MAB_BITS) ? BREAK_BITS : MAB_BITS;
  localparam int M2   = (M1 > IDLE_BITS) ? M1 : IDLE_BITS;
  localparam int MAXB = (M2 > 11) ? M2 : 11;
  localparam int BW   = $clog2(MAXB);

  localparam logic [SW-1:0] MAX_N     = SW'(MAX_SLOTS);
  localparam logic [BW-1:0] IDLE_LAST = BW'(IDLE_BITS - 1);
  localparam logic [BW-1:0] BRK_LAST  = BW'(BREAK_BITS - 1);
  localparam logic [BW-1:0] MAB_LAST  = BW'(MAB_BITS - 1);
  localparam logic [BW-1:0] SLOT_LAST = BW'(10);

  typedef enum logic [1:0] {S_IDLE, S_BREAK, S_MAB, S_SLOTS} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] baud_q;
  logic [BW-1:0] bit_q, bit_d;
  logic [SW-1:0] slot_cnt_q, slot_cnt_d;
  logic [SW-1:0] cur_q, cur_d;
  logic [SW-1:0] n_q, n_d;
  logic [10:0]   shift_q, shift_d;
  logic          dmx_q, dmx_d;
  logic          fs_q, fs_d;
  logic          fd_q, fd_d;
  logic          busy_q, busy_d;
  logic          tick;

  assign tick = (baud_q == '0);

  function automatic logic [SW-1:0] clamp_slots(input logic [SW-1:0] n);
    return (n > MAX_N) ? MAX_N : n;
  endfunction

  always_comb begin
    state_d    = state_q;
    bit_d      = bit_q;
    slot_cnt_d = slot_cnt_q;
    cur_d      = cur_q;
    n_d        = n_q;
    shift_d    = shift_q;
    dmx_d      = dmx_q;
    fs_d       = 1'b0;
    fd_d       = 1'b0;
    busy_d     = busy_q;
    if (tick) begin
      unique case (state_q)
        S_IDLE: begin
          if (bit_q != '0) begin
            bit_d = bit_q - BW'(1);
          end else if (enable) begin
            state_d = S_BREAK;
            bit_d   = BRK_LAST;
            dmx_d   = 1'b0;
            n_d     = clamp_slots(num_slots);
            fs_d    = 1'b1;
            busy_d  = 1'b1;
          end
        end
        S_BREAK: begin
          if (bit_q != '0) begin
            bit_d = bit_q - BW'(1);
          end else begin
            state_d = S_MAB;
            bit_d   = MAB_LAST;
            dmx_d   = 1'b1;
          end
        end
        S_MAB: begin
          if (bit_q != '0) begin
            bit_d = bit_q - BW'(1);
          end else begin
            state_d    = S_SLOTS;
            bit_d      = SLOT_LAST;
            shift_d    = {2'b11, start_code, 1'b0};
            dmx_d      = 1'b0;
            cur_d      = '0;
            slot_cnt_d = (n_q != '0) ? SW'(1) : '0;
          end
        end
        S_SLOTS: begin
          if (bit_q != '0) begin
            bit_d   = bit_q - BW'(1);
            shift_d = {1'b1, shift_q[10:1]};
            dmx_d   = shift_q[1];
          end else if (cur_q == n_q) begin
            state_d    = S_IDLE;
            bit_d      = IDLE_LAST;
            dmx_d      = 1'b1;
            slot_cnt_d = '0;
            fd_d       = 1'b1;
            busy_d     = 1'b0;
          end else begin
            // slot_count already points at the slot being loaded; it holds at N once reached
            bit_d   = SLOT_LAST;
            shift_d = {2'b11, slot_byte, 1'b0};
            dmx_d   = 1'b0;
            cur_d   = cur_q + SW'(1);
            if (slot_cnt_q != n_q) slot_cnt_d = slot_cnt_q + SW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK12 or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      baud_q     <= DW'(DIV - 1);
      bit_q      <= IDLE_LAST;
      slot_cnt_q <= '0;
      cur_q      <= '0;
      dmx_q      <= 1'b1;
      fs_q       <= 1'b0;
      fd_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= tick ? DW'(DIV - 1) : baud_q - DW'(1);
      bit_q      <= bit_d;
      slot_cnt_q <= slot_cnt_d;
      cur_q      <= cur_d;
      dmx_q      <= dmx_d;
      fs_q       <= fs_d;
      fd_q       <= fd_d;
      busy_q     <= busy_d;
    end
  end

  // Shifter and latched slot count only matter once loaded, so they carry no reset
  always_ff @(posedge CLK12) begin
    shift_q <= shift_d;
    n_q     <= n_d;
  end

  assign slot_count  = slot_cnt_q;
  assign dmx_data    = dmx_q;
  assign frame_start = fs_q;
  assign frame_done  = fd_q;
  assign busy        = busy_q;

endmodule
